pwm_fader: RTL and testbench

Duty-cycle sequencer that sits directly upstream of the `pwm` block and drives its `dty` input. It produces a triangular "breathing" profile: ramp up, hold at full scale, ramp down, hold at zero, repeat. Duty changes occur only on PWM period boundaries so the downstream generator never sees a mid-period change. It contains a period counter, a step prescaler, a hold counter and a 5-state FSM.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_fader.sv | 134 +++++++++++++
 tb/tb_pwm_fader.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and its duty-cycle fader.
package pwm_pkg;

    // Default duty width, shared with the downstream pwm block.
    localparam int unsigned PwmBitsDefault = 8;

    // Fader FSM states; the encoding is exported on the phase output.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StUp     = 3'd1,
        StTop    = 3'd2,
        StDown   = 3'd3,
        StBottom = 3'd4
    } fader_state_e;

endpackage

// File: rtl/pwm_fader.sv
// Triangular "breathing" duty sequencer feeding the pwm block's dty input.
// Duty only changes on PWM period boundaries; en low aborts to IDLE at once.
module pwm_fader
    import pwm_pkg::*;
#(
    parameter int unsigned BITS      = PwmBitsDefault,
    parameter int unsigned DIV_BITS  = 8,
    parameter int unsigned HOLD_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [BITS-1:0]      step,
    input  logic [DIV_BITS-1:0]  div,
    input  logic [HOLD_BITS-1:0] hold,
    output logic [BITS-1:0]      dty,
    output logic                 period_end,
    output logic [2:0]           phase
);

    localparam logic [BITS-1:0] DutyMax = '1;

    fader_state_e         state_q, state_d;
    logic [BITS-1:0]      pcnt_q, pcnt_d;
    logic [BITS-1:0]      dty_q, dty_d;
    logic [DIV_BITS-1:0]  dcnt_q, dcnt_d;
    logic [HOLD_BITS-1:0] hcnt_q, hcnt_d;

    logic [BITS-1:0]      step_eff;
    logic                 slot;

    // Period counter free-runs so boundaries stay aligned with the pwm counter.
    always_comb begin
        pcnt_d = pcnt_q + BITS'(1);
    end

    // Ramp slot decode; a zero step would stall the ramp, so it counts as one.
    always_comb begin
        period_end = (pcnt_q == '1);
        slot       = period_end && (dcnt_q == div);
        step_eff   = (step == '0) ? BITS'(1) : step;
    end

    // Next-state logic for the FSM, duty, prescaler and hold counter.
    always_comb begin
        state_d = state_q;
        dty_d   = dty_q;
        dcnt_d  = dcnt_q;
        hcnt_d  = hcnt_q;

        if (!en) begin
            // Abort wins over any slot on the same clock.
            state_d = StIdle;
            dty_d   = '0;
            dcnt_d  = '0;
        end else if (state_q == StIdle) begin
            dty_d  = '0;
            dcnt_d = '0;
            if (period_end) begin
                state_d = StUp;
            end
        end else begin
            if (period_end) begin
                dcnt_d = slot ? '0 : dcnt_q + DIV_BITS'(1);
            end
            if (slot) begin
                unique case (state_q)
                    StUp: begin
                        // Compare before adding so the sum can never wrap.
                        if (dty_q > (DutyMax - step_eff)) begin
                            dty_d   = DutyMax;
                            state_d = StTop;
                            hcnt_d  = '0;
                        end else begin
                            dty_d = dty_q + step_eff;
                        end
                    end
                    StTop: begin
                        if (hcnt_q >= hold) begin
                            state_d = StDown;
                        end else begin
                            hcnt_d = hcnt_q + HOLD_BITS'(1);
                        end
                    end
                    StDown: begin
                        if (dty_q < step_eff) begin
                            dty_d   = '0;
                            state_d = StBottom;
                            hcnt_d  = '0;
                        end else begin
                            dty_d = dty_q - step_eff;
                        end
                    end
                    StBottom: begin
                        if (hcnt_q >= hold) begin
                            state_d = StUp;
                        end else begin
                            hcnt_d = hcnt_q + HOLD_BITS'(1);
                        end
                    end
                    default: begin
                        state_d = StIdle;
                        dty_d   = '0;
                        dcnt_d  = '0;
                    end
                endcase
            end
        end
    end

    // State registers, cleared asynchronously together with the pwm block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pcnt_q  <= '0;
            dty_q   <= '0;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            dty_q   <= dty_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
        end
    end

    // Registered outputs.
    always_comb begin
        dty   = dty_q;
        phase = state_q;
    end

endmodule

// File: tb/tb_pwm_fader.sv
// Directed bench for pwm_fader with BITS=4 (16-clock periods).
module tb_pwm_fader;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] step;
    logic [7:0] div;
    logic [7:0] hold;
    logic [3:0] dty;
    logic       period_end;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    int exp_basic_d[12] = '{0, 5, 10, 15, 15, 15, 10, 5, 0, 0, 0, 5};
    int exp_basic_p[12] = '{1, 1, 1, 1, 2, 3, 3, 3, 3, 4, 1, 1};
    int exp_sat_d[11]   = '{0, 4, 8, 12, 15, 15, 11, 7, 3, 0, 0};
    int exp_sat_p[11]   = '{1, 1, 1, 1, 2, 3, 3, 3, 3, 4, 1};

    pwm_fader #(
        .BITS      (4),
        .DIV_BITS  (8),
        .HOLD_BITS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .step       (step),
        .div        (div),
        .hold       (hold),
        .dty        (dty),
        .period_end (period_end),
        .phase      (phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Advance to n rising edges after reset release, then sample 1ns later.
    task automatic adv_to(input int n);
        while (edges < n) begin
            @(posedge clk);
            edges++;
        end
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_dty", int'(dty), 0);
        check("rst_phase", int'(phase), 0);
        @(negedge clk);
        rst   = 1'b1;
        edges = 0;
    endtask

    initial begin
        rst  = 1'b0;
        en   = 1'b1;
        step = 4'd5;
        div  = 8'd0;
        hold = 8'd0;

        // Reset state with en already high.
        #12;
        check("reset_dty", int'(dty), 0);
        check("reset_phase", int'(phase), 0);
        check("reset_pe", int'(period_end), 0);
        @(negedge clk);
        rst   = 1'b1;
        edges = 0;

        // Idle until the first period_end, then basic ramp step 5.
        adv_to(14);
        check("idle_pe_low", int'(period_end), 0);
        check("idle_phase", int'(phase), 0);
        adv_to(15);
        check("first_pe", int'(period_end), 1);
        check("first_pe_phase", int'(phase), 0);
        check("first_pe_dty", int'(dty), 0);
        for (int k = 1; k <= 12; k++) begin
            adv_to(16 * k);
            check($sformatf("basic_dty_%0d", k), int'(dty), exp_basic_d[k-1]);
            check($sformatf("basic_phase_%0d", k), int'(phase), exp_basic_p[k-1]);
            if (k < 12) begin
                adv_to(16 * k + 15);
                check($sformatf("basic_pe_%0d", k), int'(period_end), 1);
                check($sformatf("basic_hold_dty_%0d", k), int'(dty), exp_basic_d[k-1]);
            end
        end

        // Saturation at MAX and no underflow with step 4.
        step = 4'd4;
        reset_dut();
        for (int k = 1; k <= 11; k++) begin
            adv_to(16 * k);
            check($sformatf("sat_dty_%0d", k), int'(dty), exp_sat_d[k-1]);
            check($sformatf("sat_phase_%0d", k), int'(phase), exp_sat_p[k-1]);
        end

        // Divider 2 and hold 1 with full-scale step.
        step = 4'd15;
        div  = 8'd2;
        hold = 8'd1;
        reset_dut();
        adv_to(63);
        check("div_pre_dty", int'(dty), 0);
        check("div_pre_phase", int'(phase), 1);
        adv_to(64);
        check("div_up_dty", int'(dty), 15);
        check("div_up_phase", int'(phase), 1);
        adv_to(111);
        check("div_up_stay", int'(phase), 1);
        adv_to(112);
        check("div_top_phase", int'(phase), 2);
        adv_to(207);
        check("div_top_stay", int'(phase), 2);
        adv_to(208);
        check("div_down_phase", int'(phase), 3);
        check("div_down_dty", int'(dty), 15);
        adv_to(255);
        check("div_down_hold", int'(dty), 15);
        adv_to(256);
        check("div_down_zero", int'(dty), 0);
        adv_to(304);
        check("div_bottom_phase", int'(phase), 4);

        // Abort mid-period from UP at dty 10, then re-enable.
        step = 4'd5;
        div  = 8'd0;
        hold = 8'd0;
        reset_dut();
        adv_to(56);
        check("abort_pre_dty", int'(dty), 10);
        check("abort_pre_phase", int'(phase), 1);
        en = 1'b0;
        adv_to(57);
        check("abort_dty", int'(dty), 0);
        check("abort_phase", int'(phase), 0);
        adv_to(60);
        en = 1'b1;
        adv_to(63);
        check("reen_wait_phase", int'(phase), 0);
        check("reen_pe", int'(period_end), 1);
        adv_to(64);
        check("reen_up_phase", int'(phase), 1);
        check("reen_up_dty", int'(dty), 0);
        adv_to(80);
        check("reen_first_step", int'(dty), 5);

        // Step zero acts as one, both up and down; then async reset mid-DOWN.
        step = 4'd0;
        reset_dut();
        adv_to(32);
        check("zero_up_1", int'(dty), 1);
        adv_to(48);
        check("zero_up_2", int'(dty), 2);
        step = 4'd15;
        adv_to(64);
        check("zero_top_dty", int'(dty), 15);
        check("zero_top_phase", int'(phase), 2);
        adv_to(80);
        check("zero_down_phase", int'(phase), 3);
        step = 4'd0;
        adv_to(96);
        check("zero_down_1", int'(dty), 14);
        adv_to(112);
        check("zero_down_2", int'(dty), 13);
        adv_to(120);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_dty", int'(dty), 0);
        check("async_rst_phase", int'(phase), 0);
        check("async_rst_pe", int'(period_end), 0);
        @(negedge clk);
        rst   = 1'b1;
        edges = 0;
        adv_to(15);
        check("restart_idle", int'(phase), 0);
        check("restart_pe", int'(period_end), 1);
        adv_to(16);
        check("restart_up", int'(phase), 1);
        check("restart_dty", int'(dty), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
